// File: rtl/sobel_stream_if.sv
// Pixel stream in and edge-magnitude stream out of the Sobel engine.
interface sobel_stream_if #(
  parameter int DW = 8,
  parameter int CW = 10
);
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_pix;
  logic          out_valid;
  logic [DW-1:0] out_pix;
  logic [CW-1:0] out_col;

  modport master (output in_valid, in_sof, in_pix, input out_valid, out_pix, out_col);
  modport slave  (input in_valid, in_sof, in_pix, output out_valid, out_pix, out_col);
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| with two on-chip line buffers; SOBEL_THRESH_EN adds a binarising threshold.
// Result 2 cycles after the completing pixel beat; no backpressure, every out_valid beat must be taken.
module sobel_stream #(
  parameter int DW    = 8,
  parameter int IMG_W = 64,
  parameter int CW    = 10
) (
  input  logic clk,
  input  logic rst,
`ifdef SOBEL_THRESH_EN
  input  logic [DW-1:0] thresh,
`endif
  sobel_stream_if.slave s
);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int GW = DW + 3;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  logic [CW-1:0] col, cur_col;
  logic [1:0]    row, cur_row;
  logic [AW-1:0] addr;

  logic [DW-1:0] lb0 [0:IMG_W-1];
  logic [DW-1:0] lb1 [0:IMG_W-1];
  logic [DW-1:0] lb0_rd, lb1_rd;

  // Two older columns of each window row; the newest column (p2, p5, p8) is the live read/input.
  logic [1:0][DW-1:0] top_q, mid_q, bot_q;

  logic                 win_vld;
  logic signed [GW-1:0] gx, gy;
  logic                 s1_vld;
  logic signed [GW-1:0] s1_gx, s1_gy;
  logic [CW-1:0]        s1_col;
  logic [GW-1:0]        abs_gx, abs_gy;
  logic [DW+3:0]        mag;
  logic [DW-1:0]        sat, res;

  function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] v);
    return $signed({3'b000, v});
  endfunction

  always_comb begin
    cur_col = s.in_sof ? '0 : col;
    cur_row = s.in_sof ? '0 : row;
  end

  assign addr    = cur_col[AW-1:0];
  assign lb0_rd  = lb0[addr];
  assign lb1_rd  = lb1[addr];
  assign win_vld = s.in_valid && (cur_row == 2'd2) && (cur_col >= CW'(2));

  // Window after this beat's shift: p0=top_q[0] p1=top_q[1] p2=lb1_rd, p3=mid_q[0] p5=lb0_rd, p6=bot_q[0] p7=bot_q[1] p8=in_pix.
  always_comb begin
    gx = (ext(lb1_rd) - ext(top_q[0]))
       + ((ext(lb0_rd) - ext(mid_q[0])) <<< 1)
       + (ext(s.in_pix) - ext(bot_q[0]));
    gy = (ext(top_q[0]) - ext(bot_q[0]))
       + ((ext(top_q[1]) - ext(bot_q[1])) <<< 1)
       + (ext(lb1_rd) - ext(s.in_pix));
  end

  // Line buffers: read-before-write at the same column, contents survive reset and start of frame.
  always_ff @(posedge clk) begin
    if (s.in_valid) begin
      lb1[addr] <= lb0_rd;
      lb0[addr] <= s.in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (s.in_valid) begin
      if (cur_col == LAST_COL) begin
        col <= '0;
        row <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
      top_q <= {lb1_rd, top_q[1]};
      mid_q <= {lb0_rd, mid_q[1]};
      bot_q <= {s.in_pix, bot_q[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_gx  <= '0;
      s1_gy  <= '0;
      s1_col <= '0;
    end else begin
      s1_vld <= win_vld;
      if (win_vld) begin
        s1_gx  <= gx;
        s1_gy  <= gy;
        s1_col <= cur_col - CW'(1);
      end
    end
  end

  always_comb begin
    abs_gx = s1_gx[GW-1] ? $unsigned(-s1_gx) : $unsigned(s1_gx);
    abs_gy = s1_gy[GW-1] ? $unsigned(-s1_gy) : $unsigned(s1_gy);
    mag    = {1'b0, abs_gx} + {1'b0, abs_gy};
    sat    = (|mag[DW+3:DW]) ? '1 : mag[DW-1:0];
`ifdef SOBEL_THRESH_EN
    res    = (sat >= thresh) ? '1 : '0;
`else
    res    = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.out_pix   <= '0;
      s.out_col   <= '0;
    end else begin
      s.out_valid <= s1_vld;
      if (s1_vld) begin
        s.out_pix <= res;
        s.out_col <= s1_col;
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: window table, image-level reference model, gap and reset sequences.
module tb_sobel_stream;
  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int CW    = 4;

  logic clk;
  logic rst;
`ifdef SOBEL_THRESH_EN
  logic [DW-1:0] thresh;
`endif

  sobel_stream_if #(.DW(DW), .CW(CW)) bus ();

  sobel_stream #(.DW(DW), .IMG_W(IMG_W), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef SOBEL_THRESH_EN
    .thresh (thresh),
`endif
    .s      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; int pix; int col; } exp_t;
  typedef struct { int w[9]; int mag; } vec_t;

  exp_t exp_q[$];
  int   seq_q[$];
  int   ref_seq[$];
  int   img[64][IMG_W];
  vec_t vecs[10];
  vec_t cur_vec;

  int tests = 0, fails = 0;
  int cyc = 0;
  int m_row = 0, m_col = 0;
  int n_out, n255, n80, col1_pix, first_cyc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, m);
    vec_t v;
    v.w[0] = a0; v.w[1] = a1; v.w[2] = a2;
    v.w[3] = a3; v.w[4] = a4; v.w[5] = a5;
    v.w[6] = a6; v.w[7] = a7; v.w[8] = a8;
    v.mag  = m;
    return v;
  endfunction

  function automatic int xf(input int mag);
    int sv;
    sv = (mag > 255) ? 255 : mag;
`ifdef SOBEL_THRESH_EN
    return (sv >= int'(thresh)) ? 255 : 0;
`else
    return sv;
`endif
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int pix_of(input int kind, input int r, input int c);
    case (kind)
      0: return 100;
      1: return (c < 4) ? 0 : 255;
      2: return 10 * (r + 1);
      3: return int'($urandom_range(0, 255));
      default: return (c < 3 && r < 3) ? cur_vec.w[r*3 + c] : 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_beat(input logic sof, input int pix);
    int a[9];
    int gx, gy;
    exp_t e;
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = pix;
    if (m_row >= 2 && m_col >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          a[i*3 + j] = img[m_row - 2 + i][m_col - 2 + j];
      gx = (a[2] - a[0]) + 2 * (a[5] - a[3]) + (a[8] - a[6]);
      gy = (a[0] - a[6]) + 2 * (a[1] - a[7]) + (a[2] - a[8]);
      e.due = cyc + 2;
      e.pix = xf(iabs(gx) + iabs(gy));
      e.col = m_col - 1;
      exp_q.push_back(e);
    end
    m_col++;
    if (m_col == IMG_W) begin
      m_col = 0;
      if (m_row < 63) m_row++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (bus.out_valid) begin
      n_out++;
      if (first_cyc < 0) first_cyc = cyc;
      if (int'(bus.out_col) == 1) col1_pix = int'(bus.out_pix);
      if (bus.out_pix == 8'hFF) n255++;
      if (int'(bus.out_pix) == xf(80)) n80++;
      seq_q.push_back(int'(bus.out_pix) * 256 + int'(bus.out_col));
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        tests++;
        fails++;
        $display("FAIL out_valid_timing: out_valid=1 at cycle %0d, next result due at %0d",
                 cyc, (exp_q.size() == 0) ? -1 : exp_q[0].due);
      end else begin
        e = exp_q.pop_front();
        check("out_pix", int'(bus.out_pix), e.pix);
        check("out_col", int'(bus.out_col), e.col);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_result: out_valid=0 at cycle %0d, expected pix %0d col %0d",
               cyc, e.pix, e.col);
    end
  endtask

  task automatic step(input logic v, input logic sof, input int pix);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_pix   = DW'(pix);
    if (v) model_beat(sof, pix);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic do_rst();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    cyc++;
    monitor();
    rst = 1'b0;
  endtask

  task automatic feed_frame(input int kind, input int nrows, input int gap_pct, input int last_cols);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < ((r == nrows - 1) ? last_cols : IMG_W); c++) begin
        for (int g = 0; g < 8; g++) begin
          if (int'($urandom_range(0, 99)) >= gap_pct) break;
          step(1'b0, 1'b0, 0);
        end
        step(1'b1, (r == 0 && c == 0), pix_of(kind, r, c));
      end
    end
  endtask

  task automatic drain();
    repeat (4) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    int c0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pix   = '0;
`ifdef SOBEL_THRESH_EN
    thresh = 8'd128;
`endif
    n_out = 0; n255 = 0; n80 = 0; col1_pix = -1; first_cyc = -1;

    vecs[0] = mkv(100, 100, 100, 100, 100, 100, 100, 100, 100, 0);
    vecs[1] = mkv(0, 0, 255, 0, 0, 255, 0, 0, 255, 1020);
    vecs[2] = mkv(10, 10, 10, 20, 20, 20, 30, 30, 30, 80);
    vecs[3] = mkv(0, 0, 0, 0, 50, 0, 0, 0, 0, 0);
    vecs[4] = mkv(10, 0, 0, 0, 0, 0, 0, 0, 0, 20);
    vecs[5] = mkv(0, 30, 0, 0, 0, 0, 0, 0, 0, 60);
    vecs[6] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 200, 400);
    vecs[7] = mkv(0, 0, 0, 0, 0, 40, 0, 0, 0, 80);
    vecs[8] = mkv(30, 30, 30, 20, 20, 20, 10, 10, 10, 80);
    vecs[9] = mkv(0, 0, 7, 0, 0, 0, 3, 0, 0, 8);

    @(negedge clk);
    do_rst();
    do_rst();
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_pix", int'(bus.out_pix), 0);
    check("reset_out_col", int'(bus.out_col), 0);

    for (int i = 0; i < 10; i++) begin
      cur_vec  = vecs[i];
      col1_pix = -1;
      feed_frame(4, 3, 0, IMG_W);
      drain();
      check($sformatf("table_vec%0d", i), col1_pix, xf(vecs[i].mag));
    end

    n_out = 0;
    feed_frame(0, 4, 0, IMG_W);
    drain();
    check("const_frame_count", n_out, 12);

    n_out = 0; n255 = 0; seq_q.delete();
    feed_frame(1, 4, 0, IMG_W);
    drain();
    check("step_count", n_out, 12);
    check("step_edges", n255, 4);
    ref_seq = seq_q;

    n_out = 0; n80 = 0;
    feed_frame(2, 4, 0, IMG_W);
    drain();
    check("gradient_count", n80, 12);

    seq_q.delete();
    feed_frame(1, 4, 50, IMG_W);
    drain();
    check("gap_seq_len", seq_q.size(), ref_seq.size());
    for (int i = 0; i < seq_q.size() && i < ref_seq.size(); i++)
      check($sformatf("gap_seq%0d", i), seq_q[i], ref_seq[i]);

    feed_frame(1, 3, 0, 5);
    do_rst();
    check("rst_out_valid_low", int'(bus.out_valid), 0);
    first_cyc = -1;
    c0 = cyc;
    feed_frame(1, 3, 0, IMG_W);
    drain();
    check("rst_first_out_cycle", first_cyc, c0 + 2 * IMG_W + 2 + 2);

`ifdef SOBEL_THRESH_EN
    thresh = 8'd0;
    n255 = 0;
    feed_frame(1, 4, 0, IMG_W);
    drain();
    check("thresh0_all_ones", n255, 12);
    thresh = 8'd128;
`endif

    for (int f = 0; f < 8; f++) begin
      feed_frame(3, int'($urandom_range(3, 5)), int'($urandom_range(0, 60)),
                 int'($urandom_range(1, IMG_W)));
    end
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
